// File: rtl/i2c_temp_poller.sv
// i2c_temp_poller: I2C read master polling NUM_CH sensors in round-robin.
// Each transaction: START, {ADDR_BASE+ch, R}, BYTES data bytes (MSB first),
// master ACK/NACK, STOP, then GAP_BITS idle bit-times before the next START.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   ena              level; 1 = keep polling
//   sda_i, scl_i     sampled bus lines (scl_i only used with clock stretching)
//   sda_oe, scl_oe   1 = pull line low, 0 = release
//   busy             high from first clk of START to last clk of STOP
//   rd_valid         one-cycle result strobe
//   rd_ch            channel of the result
//   rd_data          bytes read, first byte in the MSBs
//   rd_err           address NACK seen (qualified by rd_valid)
//
// Optional feature macro: I2C_SCL_STRETCH_EN (slave clock stretching in Q2).
module i2c_temp_poller #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned NUM_CH    = 2,
  parameter logic [6:0]  ADDR_BASE = 7'h48,
  parameter int unsigned BYTES     = 2,
  parameter int unsigned GAP_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ena,
  input  logic                 sda_i,
  input  logic                 scl_i,
  output logic                 sda_oe,
  output logic                 scl_oe,
  output logic                 busy,
  output logic                 rd_valid,
  output logic [2:0]           rd_ch,
  output logic [8*BYTES-1:0]   rd_data,
  output logic                 rd_err
);

  localparam int unsigned QW = $clog2(CLK_DIV);
  localparam int unsigned DW = 8 * BYTES;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_RDATA, S_MACK, S_STOP, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt;
  logic [1:0]      quarter;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [15:0]     gap_cnt;
  logic [2:0]      ch;
  logic [DW-1:0]   sreg;
  logic            err;
  logic            hold, q_end, bit_end, sample, last_byte;
  logic [7:0]      addr_byte;

`ifdef I2C_SCL_STRETCH_EN
  assign hold = (quarter == 2'd2) && !scl_oe && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign hold = 1'b0;
`endif

  assign q_end     = !hold && (qcnt == QW'(CLK_DIV - 1));
  assign bit_end   = q_end && (quarter == 2'd3);
  assign sample    = q_end && (quarter == 2'd2);
  assign last_byte = (byte_cnt == 2'(BYTES - 1));
  assign addr_byte = {ADDR_BASE + {4'd0, ch}, 1'b1};

  // Line drivers depend only on state and quarter, kept apart from the
  // next-state logic so the stretch hold path has no combinational loop.
  // START keeps SCL released for the whole bit and drops SDA at Q2.
  always_comb begin
    sda_oe = 1'b0;
    scl_oe = 1'b0;
    busy   = 1'b0;
    case (state_q)
      S_START: begin busy = 1'b1; sda_oe = quarter[1]; end
      S_ADDR:  begin busy = 1'b1; scl_oe = !quarter[1]; sda_oe = !addr_byte[3'd7 - bit_cnt]; end
      S_AACK:  begin busy = 1'b1; scl_oe = !quarter[1]; end
      S_RDATA: begin busy = 1'b1; scl_oe = !quarter[1]; end
      S_MACK:  begin busy = 1'b1; scl_oe = !quarter[1]; sda_oe = !last_byte; end
      S_STOP:  begin busy = 1'b1; scl_oe = !quarter[1]; sda_oe = (quarter != 2'd3); end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ena) state_d = S_START;
      S_START: if (bit_end) state_d = S_ADDR;
      S_ADDR:  if (bit_end && bit_cnt == 3'd7) state_d = S_AACK;
      S_AACK:  if (bit_end) state_d = err ? S_STOP : S_RDATA;
      S_RDATA: if (bit_end && bit_cnt == 3'd7) state_d = S_MACK;
      S_MACK:  if (bit_end) state_d = last_byte ? S_STOP : S_RDATA;
      S_STOP:  if (bit_end) state_d = S_GAP;
      S_GAP:   if (bit_end && gap_cnt == 16'(GAP_BITS - 1)) state_d = ena ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      qcnt    <= '0;
      quarter <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        qcnt    <= '0;
        quarter <= '0;
      end else if (q_end) begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
      end else if (!hold) begin
        qcnt    <= qcnt + QW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      ch       <= '0;
      sreg     <= '0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_ch    <= '0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state_q)
        S_START: begin
          sreg     <= '0;
          err      <= 1'b0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end
        S_ADDR:  if (bit_end) bit_cnt <= bit_cnt + 3'd1;
        S_AACK:  if (sample) err <= sda_i;
        S_RDATA: begin
          if (sample)  sreg    <= {sreg[DW-2:0], sda_i};
          if (bit_end) bit_cnt <= bit_cnt + 3'd1;
        end
        S_MACK:  if (bit_end) byte_cnt <= byte_cnt + 2'd1;
        S_STOP: begin
          gap_cnt <= '0;
          if (bit_end) begin
            rd_valid <= 1'b1;
            rd_ch    <= ch;
            rd_data  <= sreg;
            rd_err   <= err;
            ch       <= (ch == 3'(NUM_CH - 1)) ? '0 : ch + 3'd1;
          end
        end
        S_GAP:   if (bit_end) gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_temp_poller.sv
module tb_i2c_temp_poller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ena0 = 1'b0, ena1 = 1'b0;
  always #5 clk = ~clk;

  logic        sda_oe0, scl_oe0, busy0, rd_valid0, rd_err0;
  logic [2:0]  rd_ch0;
  logic [15:0] rd_data0;
  logic        sda_oe1, scl_oe1, busy1, rd_valid1, rd_err1;
  logic [2:0]  rd_ch1;
  logic [7:0]  rd_data1;

  logic [1:0] slv_drv = 2'b00;
  logic [1:0] stretch = 2'b00;
  logic sda_line0, scl_line0, sda_line1, scl_line1;
  assign sda_line0 = ~sda_oe0 & ~slv_drv[0];
  assign scl_line0 = ~scl_oe0 & ~stretch[0];
  assign sda_line1 = ~sda_oe1 & ~slv_drv[1];
  assign scl_line1 = ~scl_oe1 & ~stretch[1];

  i2c_temp_poller u0 (
    .clk(clk), .reset_n(reset_n), .ena(ena0), .sda_i(sda_line0), .scl_i(scl_line0),
    .sda_oe(sda_oe0), .scl_oe(scl_oe0), .busy(busy0), .rd_valid(rd_valid0),
    .rd_ch(rd_ch0), .rd_data(rd_data0), .rd_err(rd_err0)
  );

  i2c_temp_poller #(.NUM_CH(1), .BYTES(1)) u1 (
    .clk(clk), .reset_n(reset_n), .ena(ena1), .sda_i(sda_line1), .scl_i(scl_line1),
    .sda_oe(sda_oe1), .scl_oe(scl_oe1), .busy(busy1), .rd_valid(rd_valid1),
    .rd_ch(rd_ch1), .rd_data(rd_data1), .rd_err(rd_err1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model (one per DUT) ----------------
  typedef enum int {P_IDLE, P_ADDR, P_SACK, P_DATA, P_MACK} ph_t;
  ph_t        phase [2];
  int         cnt [2], bidx [2], st_cnt [2], mack_n [2];
  logic [7:0] shreg [2], addr_seen [2], mack_log [2];
  logic [7:0] sdata [2][4];
  logic       mbit [2], prev_scl [2], prev_sda [2], stretch_arm [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      phase[k] = P_IDLE; cnt[k] = 0; bidx[k] = 0; st_cnt[k] = 0; mack_n[k] = 0;
      shreg[k] = '0; addr_seen[k] = '0; mack_log[k] = '0; mbit[k] = 1'b1;
      prev_scl[k] = 1'b1; prev_sda[k] = 1'b1; stretch_arm[k] = 1'b0;
    end
    sdata[0][0] = 8'h19; sdata[0][1] = 8'h80; sdata[0][2] = 8'h00; sdata[0][3] = 8'h00;
    sdata[1][0] = 8'hA5; sdata[1][1] = 8'h00; sdata[1][2] = 8'h00; sdata[1][3] = 8'h00;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic mscl, msda, cs, cd;
        logic [7:0] cur;
        mscl = (k == 0) ? scl_oe0 : scl_oe1;
        msda = (k == 0) ? sda_oe0 : sda_oe1;
        if (stretch[k] && !mscl) begin
          if (st_cnt[k] == 50) stretch[k] = 1'b0;
          else st_cnt[k]++;
        end
        cs = ~mscl & ~stretch[k];
        cd = ~msda & ~slv_drv[k];
        if (prev_scl[k] && cs && prev_sda[k] && !cd) begin
          phase[k] = P_ADDR; cnt[k] = 0; slv_drv[k] = 1'b0;
        end else if (prev_scl[k] && cs && !prev_sda[k] && cd) begin
          phase[k] = P_IDLE; slv_drv[k] = 1'b0;
        end else if (!prev_scl[k] && cs) begin
          case (phase[k])
            P_ADDR: begin shreg[k] = {shreg[k][6:0], cd}; cnt[k]++; end
            P_DATA: cnt[k]++;
            P_MACK: begin mbit[k] = cd; mack_log[k] = {mack_log[k][6:0], cd}; mack_n[k]++; end
            default: ;
          endcase
        end else if (prev_scl[k] && !cs) begin
          case (phase[k])
            P_ADDR: if (cnt[k] == 8) begin
              addr_seen[k] = shreg[k];
              if (shreg[k] == {7'h48, 1'b1}) begin slv_drv[k] = 1'b1; phase[k] = P_SACK; end
              else phase[k] = P_IDLE;
            end
            P_SACK: begin
              phase[k] = P_DATA; cnt[k] = 0; bidx[k] = 0;
              cur = sdata[k][0];
              slv_drv[k] = ~cur[7];
              if (stretch_arm[k]) begin stretch_arm[k] = 1'b0; stretch[k] = 1'b1; st_cnt[k] = 0; end
            end
            P_DATA: begin
              if (cnt[k] >= 8) begin phase[k] = P_MACK; slv_drv[k] = 1'b0; end
              else begin cur = sdata[k][bidx[k] & 3]; slv_drv[k] = ~cur[7 - cnt[k]]; end
            end
            P_MACK: begin
              bidx[k]++;
              if (!mbit[k]) begin
                phase[k] = P_DATA; cnt[k] = 0;
                cur = sdata[k][bidx[k] & 3];
                slv_drv[k] = ~cur[7];
              end else begin
                phase[k] = P_IDLE; slv_drv[k] = 1'b0;
              end
            end
            default: ;
          endcase
        end
        prev_scl[k] = cs;
        prev_sda[k] = cd;
      end
    end
  end

  // ---------------- output monitor ----------------
  int         n_start [2], n_strobe [2], multi [2];
  int         start_cyc [2], st_cyc [2], lat [2], gap [2];
  logic [2:0] st_ch [2];
  logic [31:0] st_data [2];
  logic       st_err [2], pbusy [2], pval [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      n_start[k] = 0; n_strobe[k] = 0; multi[k] = 0; start_cyc[k] = 0; st_cyc[k] = 0;
      lat[k] = 0; gap[k] = 0; st_ch[k] = '0; st_data[k] = '0; st_err[k] = 1'b0;
      pbusy[k] = 1'b0; pval[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic b, v;
        b = (k == 0) ? busy0 : busy1;
        v = (k == 0) ? rd_valid0 : rd_valid1;
        if (b && !pbusy[k]) begin n_start[k]++; gap[k] = cyc - st_cyc[k]; start_cyc[k] = cyc; end
        if (v) begin
          if (pval[k]) multi[k]++;
          n_strobe[k]++; st_cyc[k] = cyc; lat[k] = cyc - start_cyc[k];
          st_ch[k]   = (k == 0) ? rd_ch0 : rd_ch1;
          st_data[k] = (k == 0) ? {16'h0, rd_data0} : {24'h0, rd_data1};
          st_err[k]  = (k == 0) ? rd_err0 : rd_err1;
        end
        pbusy[k] = b; pval[k] = v;
      end
    end
  end

  // ---------------- helpers (waiting only) ----------------
  task automatic wait_strobe(input int k, input int budget, output bit ok);
    int n0;
    n0 = n_strobe[k];
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_strobe[k] != n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int k, input int budget, output bit ok);
    int n0;
    n0 = n_start[k];
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_start[k] != n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sda_oe0, scl_oe0, busy0, rd_valid0, rd_err0} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {sda_oe0, scl_oe0, busy0, rd_valid0, rd_err0});
    end
    checks++;
    if ({rd_ch0, rd_data0} !== 19'h0) begin
      errors++; $display("FAIL reset_data: got ch=%0d data=%h expected ch=0 data=0000", rd_ch0, rd_data0);
    end
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (n_start[0] != 0 || busy0 !== 1'b0 || sda_oe0 !== 1'b0 || scl_oe0 !== 1'b0) begin
      errors++; $display("FAIL idle_no_activity: got starts=%0d busy=%b expected 0 0", n_start[0], busy0);
    end
  endtask

  task automatic test_ack_read();
    bit ok;
    mack_n[0] = 0; mack_log[0] = '0;
    ena0 = 1'b1;
    wait_strobe(0, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ack_read_timeout: got no strobe expected one"); end
    checks++;
    if (st_ch[0] !== 3'd0 || st_err[0] !== 1'b0) begin
      errors++; $display("FAIL ack_read_ch_err: got ch=%0d err=%b expected ch=0 err=0", st_ch[0], st_err[0]);
    end
    checks++;
    if (st_data[0] !== 32'h1980) begin errors++; $display("FAIL ack_read_data: got %h expected 1980", st_data[0]); end
    checks++;
    if (lat[0] != 464) begin errors++; $display("FAIL ack_read_latency: got %0d expected 464", lat[0]); end
    checks++;
    if (addr_seen[0] !== 8'h91) begin errors++; $display("FAIL ack_read_addr: got %h expected 91", addr_seen[0]); end
    checks++;
    if (mack_n[0] != 2 || mack_log[0][1:0] !== 2'b01) begin
      errors++; $display("FAIL ack_read_mack: got n=%0d bits=%b expected n=2 bits=01", mack_n[0], mack_log[0][1:0]);
    end
  endtask

  task automatic test_nack_wrap_ena_drop();
    bit ok;
    int ns;
    wait_strobe(0, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nack_timeout: got no strobe expected one"); end
    checks++;
    if (st_ch[0] !== 3'd1 || st_err[0] !== 1'b1 || st_data[0] !== 32'h0) begin
      errors++; $display("FAIL nack_result: got ch=%0d err=%b data=%h expected ch=1 err=1 data=0000", st_ch[0], st_err[0], st_data[0]);
    end
    checks++;
    if (addr_seen[0] !== 8'h93) begin errors++; $display("FAIL nack_addr: got %h expected 93", addr_seen[0]); end
    checks++;
    if (lat[0] != 176) begin errors++; $display("FAIL nack_latency: got %0d expected 176", lat[0]); end
    wait_start(0, 1000, ok);
    checks++;
    if (!ok || gap[0] != 128) begin errors++; $display("FAIL gap_length: got %0d expected 128", gap[0]); end
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (phase[0] == P_DATA && bidx[0] == 1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ena_drop_wait: got no second byte expected one"); end
    ena0 = 1'b0;
    wait_strobe(0, 2000, ok);
    checks++;
    if (!ok || st_ch[0] !== 3'd0 || st_data[0] !== 32'h1980 || st_err[0] !== 1'b0) begin
      errors++; $display("FAIL wrap_result: got ch=%0d data=%h err=%b expected ch=0 data=1980 err=0", st_ch[0], st_data[0], st_err[0]);
    end
    checks++;
    if (addr_seen[0] !== 8'h91) begin errors++; $display("FAIL wrap_addr: got %h expected 91", addr_seen[0]); end
    ns = n_start[0];
    repeat (400) @(negedge clk);
    checks++;
    if (n_start[0] != ns || busy0 !== 1'b0 || sda_oe0 !== 1'b0 || scl_oe0 !== 1'b0) begin
      errors++; $display("FAIL ena_drop_idle: got extra_starts=%0d busy=%b sda_oe=%b scl_oe=%b expected 0 0 0 0",
                         n_start[0] - ns, busy0, sda_oe0, scl_oe0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ena0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (phase[0] == P_ADDR && cnt[0] == 1 && scl_oe0 === 1'b1) begin ok = 1'b1; break; end
    end
    #1;
    checks++;
    if (!ok || sda_oe0 !== 1'b1) begin errors++; $display("FAIL reset_mid_pre: got sda_oe=%b expected 1", sda_oe0); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (sda_oe0 !== 1'b0 || scl_oe0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL reset_mid_release: got sda_oe=%b scl_oe=%b busy=%b expected 0 0 0", sda_oe0, scl_oe0, busy0);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_strobe(0, 3000, ok);
    checks++;
    if (!ok || st_ch[0] !== 3'd0 || addr_seen[0] !== 8'h91 || lat[0] != 464) begin
      errors++; $display("FAIL reset_mid_restart: got ch=%0d addr=%h lat=%0d expected ch=0 addr=91 lat=464", st_ch[0], addr_seen[0], lat[0]);
    end
  endtask

  task automatic test_stretch();
    bit ok;
    int exp_lat;
    ena0 = 1'b0;
    pulse_reset();
    stretch_arm[0] = 1'b1;
    ena0 = 1'b1;
    wait_strobe(0, 3000, ok);
    ena0 = 1'b0;
`ifdef I2C_SCL_STRETCH_EN
    exp_lat = 514;
    checks++;
    if (st_data[0] !== 32'h1980) begin errors++; $display("FAIL stretch_data: got %h expected 1980", st_data[0]); end
`else
    exp_lat = 464;
`endif
    checks++;
    if (!ok || lat[0] != exp_lat) begin errors++; $display("FAIL stretch_latency: got %0d expected %0d", lat[0], exp_lat); end
    pulse_reset();
  endtask

  task automatic test_single_byte();
    bit ok;
    mack_n[1] = 0; mack_log[1] = '0;
    ena1 = 1'b1;
    wait_strobe(1, 3000, ok);
    checks++;
    if (!ok || st_data[1] !== 32'hA5 || st_ch[1] !== 3'd0 || st_err[1] !== 1'b0) begin
      errors++; $display("FAIL single_result: got data=%h ch=%0d err=%b expected data=a5 ch=0 err=0", st_data[1], st_ch[1], st_err[1]);
    end
    checks++;
    if (lat[1] != 320) begin errors++; $display("FAIL single_latency: got %0d expected 320", lat[1]); end
    checks++;
    if (mack_n[1] != 1 || mack_log[1][0] !== 1'b1) begin
      errors++; $display("FAIL single_mack: got n=%0d bit=%b expected n=1 bit=1", mack_n[1], mack_log[1][0]);
    end
    wait_strobe(1, 3000, ok);
    ena1 = 1'b0;
    checks++;
    if (!ok || st_ch[1] !== 3'd0 || addr_seen[1] !== 8'h91) begin
      errors++; $display("FAIL single_wrap: got ch=%0d addr=%h expected ch=0 addr=91", st_ch[1], addr_seen[1]);
    end
  endtask

  initial begin
    test_reset();
    test_ack_read();
    test_nack_wrap_ena_drop();
    test_reset_mid();
    test_stretch();
    test_single_byte();
    checks++;
    if (multi[0] != 0 || multi[1] != 0) begin
      errors++; $display("FAIL strobe_width: got extra_cycles=%0d/%0d expected 0/0", multi[0], multi[1]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_temp_poller.md
Name: i2c_temp_poller

Overview:
- Parametrised I2C read master that polls NUM_CH temperature sensors in round-robin, one after another.
- Each sensor transaction: START, 7-bit address + R, BYTES data bytes MSB first, STOP.
- Delivers each result as a one-cycle strobe with channel index to the display/formatting logic downstream.
- Successor to the single-address, single-byte read path: adds channel count, byte count, address-NACK error reporting and inter-poll gap.

Parameters:
- CLK_DIV, 4: clk cycles per quarter SCL bit; one bit-time = 4*CLK_DIV clk cycles; legal range >= 2.
- NUM_CH, 2: number of sensors; channel i uses address ADDR_BASE+i; legal range 1..8.
- ADDR_BASE, 7'h48: 7-bit address of channel 0.
- BYTES, 2: data bytes read per transaction; legal range 1..4.
- GAP_BITS, 8: idle bit-times between STOP and the next START.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ena  in  1  level; 1 = keep polling.
- sda_i  in  1  sampled SDA line.
- scl_i  in  1  sampled SCL line; used only with the optional feature.
- sda_oe  out  1  1 = drive SDA low, 0 = release.
- scl_oe  out  1  1 = drive SCL low, 0 = release.
- busy  out  1  high from START through end of STOP.
- rd_valid  out  1  one-cycle result strobe.
- rd_ch  out  3  channel of the current result.
- rd_data  out  8*BYTES  bytes concatenated, first byte in the MSBs.
- rd_err  out  1  address NACK seen; qualified by rd_valid.

Behaviour:
- Reset, asynchronous: sda_oe=0, scl_oe=0, busy=0, rd_valid=0, rd_ch=0, rd_data=0, rd_err=0. State = IDLE; channel pointer = 0; quarter counter = 0.
- Reset asserted mid-transaction releases both lines immediately, with no STOP generated.
- Bit timing: each bit has quarters Q0..Q3, each CLK_DIV clk cycles long.
  - SCL is low in Q0/Q1 and released in Q2/Q3.
  - The master changes SDA only at the Q0 start.
  - The master samples sda_i on the last clk of Q2.
- States:
  - IDLE: when ena=1, go to START on the next clk.
  - START: one bit-time. SDA low during Q2 while SCL is high; SCL is pulled low at Q0 of the next state.
  - ADDR: 8 bits, {ADDR_BASE+ch, 1'b1}, MSB first.
  - AACK: releases SDA and samples it. 0 -> RDATA. 1 -> set err flag, then STOP.
  - RDATA: 8 bits, SDA released, shifted in MSB first.
  - MACK: drives ACK (SDA low) after every byte except the last; drives NACK (SDA released) after the last. After the last byte -> STOP, otherwise -> RDATA.
  - STOP: one bit-time. SDA low in Q0..Q2, released in Q3 while SCL is high.
  - GAP: GAP_BITS bit-times with both lines released, then START if ena=1, else IDLE.
- Result strobe: on the last clk of STOP, rd_valid=1 for exactly one cycle.
  - rd_ch = channel just polled; rd_data = shift register contents; rd_err = err flag.
  - On an error, rd_data holds all bytes shifted in before the NACK. These are zero, because the shift register clears at START.
- Channel pointer advances at STOP and wraps from NUM_CH-1 to 0.
- ena deasserted mid-transaction: the current transaction completes, including its strobe, then IDLE after GAP.
- ena=0 in IDLE: no activity.
- busy is high from the first clk of START to the last clk of STOP inclusive.
- Latency: the successful transaction is (2 + 9*(1+BYTES)) bit-times from START entry to the strobe. Defaults: 29*16 = 464 clk.

Optional Feature:
- Macro: I2C_SCL_STRETCH_EN.
- Defined: during Q2, while scl_oe=0 and scl_i=0, the quarter counter holds, so a slave can stretch the clock. Timing resumes on the first clk with scl_i=1.
- Not defined: scl_i is ignored and the timing is fixed.

Test Plan:
- Slave model at 7'h48 ACKs and returns 8'h19, 8'h80 (CLK_DIV=4, NUM_CH=2, BYTES=2) -> rd_valid once, rd_ch=0, rd_data=16'h1980, rd_err=0, 464 clk after START. SDA bit sequence 1001000_1, ACK, data, ACK, NACK.
- Next poll with no slave at 7'h49 -> rd_ch=1, rd_err=1, rd_data=16'h0000. STOP follows the address bit 9 immediately. The following poll addresses 7'h48 (wrap).
- ena dropped during the second data byte -> transaction completes with a strobe, then GAP (8 bit-times = 128 clk), then IDLE with both oe=0 and no further START.
- reset_n pulsed low during the ADDR state -> sda_oe and scl_oe are 0 in the same cycle. After release with ena=1, START begins at channel 0.
- With I2C_SCL_STRETCH_EN defined and the slave holding scl_i=0 for 50 clk on the first data bit -> latency grows by exactly 50 clk and data is unchanged. Without the macro, latency stays at 464.
- BYTES=1, NUM_CH=1, slave returns 8'hA5 -> rd_data=8'hA5, and the MACK bit is NACK.
